ysyx_23060240_trap_ctrl: RTL and testbench

Sequencer for machine-mode trap entry and return in the single-issue core. It owns the one CSR write port and the CSR read address. It arbitrates between trap sequencing (interrupt, ecall, mret) and ordinary CSR-instruction writes. It drives a PC redirect to mtvec or mepc once the CSR state is committed, and holds the pipeline stalled while a sequence runs.

---
 rtl/ysyx_23060240_csr_pkg.sv | 36 +++
 rtl/ysyx_23060240_trap_ctrl_if.sv | 35 +++
 rtl/ysyx_23060240_trap_prio.sv | 37 +++
 rtl/ysyx_23060240_trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060240_trap_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared CSR addresses, mstatus field positions, trap causes and sequencer encodings
// for the machine-mode trap controller.
package ysyx_23060240_csr_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  localparam logic [31:0] CauseEcall = 32'h0000_000b;
  localparam logic [31:0] CauseMti   = 32'h8000_0007;

  typedef enum logic [2:0] {
    StIdle,
    StTEpc,
    StTCause,
    StTStat,
    StTVec,
    StMStat,
    StMEpc,
    StRedir
  } state_e;

  typedef struct packed {
    logic irq;
    logic ecall;
    logic mret;
    logic inst;
  } accept_t;

endpackage

// File: rtl/ysyx_23060240_trap_ctrl_if.sv
// Execute/fetch/CSR-file side signals of the trap controller, grouped with modports.
interface ysyx_23060240_trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] ex_pc;
  logic            ecall_req;
  logic            mret_req;
  logic            irq_pending;
  logic            inst_csr_wen;
  logic [11:0]     inst_csr_waddr;
  logic [XLEN-1:0] inst_csr_wdata;
  logic            inst_csr_ready;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  ex_pc, ecall_req, mret_req, irq_pending, inst_csr_wen, inst_csr_waddr,
           inst_csr_wdata, csr_rdata,
    output inst_csr_ready, csr_wen, csr_waddr, csr_wdata, csr_raddr, busy,
           redirect_valid, redirect_pc
  );

  modport master (
    output ex_pc, ecall_req, mret_req, irq_pending, inst_csr_wen, inst_csr_waddr,
           inst_csr_wdata, csr_rdata,
    input  inst_csr_ready, csr_wen, csr_waddr, csr_wdata, csr_raddr, busy,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060240_trap_prio.sv
// Fixed-priority select of the single source accepted in an idle cycle:
// enabled interrupt, ecall, mret, then an ordinary CSR-instruction write.
module ysyx_23060240_trap_prio
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  CAUSE_ECALL = CauseEcall,
  parameter logic [XLEN-1:0]  CAUSE_MTI   = CauseMti
) (
  input  logic            en_i,
  input  logic            irq_i,
  input  logic            mie_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            inst_wen_i,
  output accept_t         accept_o,
  output logic [XLEN-1:0] cause_o
);

  always_comb begin
    accept_o = '0;
    cause_o  = CAUSE_ECALL;
    if (en_i) begin
      if (irq_i && mie_i) begin
        accept_o.irq = 1'b1;
        cause_o      = CAUSE_MTI;
      end else if (ecall_i) begin
        accept_o.ecall = 1'b1;
      end else if (mret_i) begin
        accept_o.mret = 1'b1;
      end else if (inst_wen_i) begin
        accept_o.inst = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060240_trap_ctrl.sv
// Machine-mode trap entry/return sequencer: owns the CSR write port and read address,
// commits mepc/mcause/mstatus, then pulses a PC redirect to mtvec or mepc.
module ysyx_23060240_trap_ctrl
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  CAUSE_ECALL = CauseEcall,
  parameter logic [XLEN-1:0]  CAUSE_MTI   = CauseMti
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_23060240_trap_ctrl_if.slave     bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  accept_t         accept;
  logic [XLEN-1:0] cause_sel;
  logic [XLEN-1:0] stat;
  logic [XLEN-1:0] vec_off;

  ysyx_23060240_trap_prio #(
    .XLEN        (XLEN),
    .CAUSE_ECALL (CAUSE_ECALL),
    .CAUSE_MTI   (CAUSE_MTI)
  ) u_prio (
    .en_i       (rst_n && (state_q == StIdle)),
    .irq_i      (bus.irq_pending),
    .mie_i      (bus.csr_rdata[MstatusMie]),
    .ecall_i    (bus.ecall_req),
    .mret_i     (bus.mret_req),
    .inst_wen_i (bus.inst_csr_wen),
    .accept_o   (accept),
    .cause_o    (cause_sel)
  );

  // Vectored mode offset is 4*cause, truncated to XLEN bits.
  assign vec_off = {cause_q[XLEN-3:0], 2'b00};

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    cause_d            = cause_q;
    tgt_d              = tgt_q;
    stat               = bus.csr_rdata;
    bus.inst_csr_ready = 1'b0;
    bus.csr_wen        = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.csr_raddr      = '0;
    bus.busy           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    unique case (state_q)
      StIdle: begin
        // Held at zero during reset so every output reads 0.
        if (rst_n) bus.csr_raddr = CsrMstatus;
        if (accept.irq || accept.ecall) begin
          bus.busy = 1'b1;
          pc_d     = bus.ex_pc;
          cause_d  = cause_sel;
          state_d  = StTEpc;
        end else if (accept.mret) begin
          bus.busy = 1'b1;
          state_d  = StMStat;
        end else if (accept.inst) begin
          bus.inst_csr_ready = 1'b1;
          bus.csr_wen        = 1'b1;
          bus.csr_waddr      = bus.inst_csr_waddr;
          bus.csr_wdata      = bus.inst_csr_wdata;
        end
      end
      StTEpc: begin
        bus.busy      = 1'b1;
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CsrMepc;
        bus.csr_wdata = pc_q;
        state_d       = StTCause;
      end
      StTCause: begin
        bus.busy      = 1'b1;
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CsrMcause;
        bus.csr_wdata = cause_q;
        state_d       = StTStat;
      end
      StTStat: begin
        bus.busy                         = 1'b1;
        bus.csr_raddr                    = CsrMstatus;
        stat[MstatusMpie]                = bus.csr_rdata[MstatusMie];
        stat[MstatusMie]                 = 1'b0;
        stat[MstatusMppHi:MstatusMppLo]  = 2'b11;
        bus.csr_wen                      = 1'b1;
        bus.csr_waddr                    = CsrMstatus;
        bus.csr_wdata                    = stat;
        state_d                          = StTVec;
      end
      StTVec: begin
        bus.busy      = 1'b1;
        bus.csr_raddr = CsrMtvec;
        tgt_d         = {bus.csr_rdata[XLEN-1:2], 2'b00};
        if (bus.csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1]) tgt_d = tgt_d + vec_off;
        state_d       = StRedir;
      end
      StMStat: begin
        bus.busy                         = 1'b1;
        bus.csr_raddr                    = CsrMstatus;
        stat[MstatusMie]                 = bus.csr_rdata[MstatusMpie];
        stat[MstatusMpie]                = 1'b1;
        stat[MstatusMppHi:MstatusMppLo]  = 2'b11;
        bus.csr_wen                      = 1'b1;
        bus.csr_waddr                    = CsrMstatus;
        bus.csr_wdata                    = stat;
        state_d                          = StMEpc;
      end
      StMEpc: begin
        bus.busy      = 1'b1;
        bus.csr_raddr = CsrMepc;
        tgt_d         = {bus.csr_rdata[XLEN-1:2], 2'b00};
        state_d       = StRedir;
      end
      StRedir: begin
        bus.busy           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// Directed bench for the trap controller: a CSR-file model, expected CSR writes and
// redirects queued by the stimulus, and a negedge monitor that pops and compares them.
module tb_ysyx_23060240_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_23060240_trap_ctrl_if #(.XLEN(32)) bus ();

  ysyx_23060240_trap_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // CSR file model, written only through the DUT write port.
  logic [31:0] r_mstatus = '0;
  logic [31:0] r_mtvec   = '0;
  logic [31:0] r_mepc    = '0;
  logic [31:0] r_mcause  = '0;

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      12'h300: bus.csr_rdata = r_mstatus;
      12'h305: bus.csr_rdata = r_mtvec;
      12'h341: bus.csr_rdata = r_mepc;
      12'h342: bus.csr_rdata = r_mcause;
      default: bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_wen) begin
      case (bus.csr_waddr)
        12'h300: r_mstatus <= bus.csr_wdata;
        12'h305: r_mtvec   <= bus.csr_wdata;
        12'h341: r_mepc    <= bus.csr_wdata;
        12'h342: r_mcause  <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] pc; int at; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    wq.push_back('{a: a, d: d});
  endtask

  task automatic exp_rd(input logic [31:0] pc, input int lat);
    rq.push_back('{pc: pc, at: cyc + lat});
  endtask

  always @(negedge clk) begin
    if (bus.csr_wen) begin
      if (wq.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bus.csr_waddr,
                 bus.csr_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 64'(bus.csr_waddr), 64'(e.a));
        chk("wr_data", 64'(bus.csr_wdata), 64'(e.d));
      end
    end
    if (bus.redirect_valid) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL unexpected_redirect: pc 0x%0h, none expected", bus.redirect_pc);
      end else begin
        rd_t r;
        r = rq.pop_front();
        chk("redirect_pc", 64'(bus.redirect_pc), 64'(r.pc));
        chk("redirect_cycle", 64'(cyc), 64'(r.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic inst_wr(input logic [11:0] a, input logic [31:0] d);
    bus.inst_csr_wen   = 1'b1;
    bus.inst_csr_waddr = a;
    bus.inst_csr_wdata = d;
    exp_wr(a, d);
    #1;
    chk("inst_ready", 64'(bus.inst_csr_ready), 64'd1);
    chk("inst_wen", 64'(bus.csr_wen), 64'd1);
    tick();
    bus.inst_csr_wen = 1'b0;
  endtask

  // Raise ecall (and optionally irq) for the accept cycle only; execute drops them once stalled.
  task automatic trap(input logic irq, input logic [31:0] pc, input logic [31:0] tgt);
    bus.ecall_req   = 1'b1;
    bus.irq_pending = irq;
    bus.ex_pc       = pc;
    exp_rd(tgt, 5);
    #1;
    chk("accept_busy", 64'(bus.busy), 64'd1);
    tick();
    bus.ecall_req   = 1'b0;
    bus.irq_pending = 1'b0;
    wait_idle();
  endtask

  function automatic logic all_out();
    return |{bus.inst_csr_ready, bus.csr_wen, bus.csr_waddr, bus.csr_wdata, bus.csr_raddr,
             bus.busy, bus.redirect_valid, bus.redirect_pc};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_pc          = '0;
    bus.ecall_req      = 1'b0;
    bus.mret_req       = 1'b0;
    bus.irq_pending    = 1'b0;
    bus.inst_csr_wen   = 1'b0;
    bus.inst_csr_waddr = '0;
    bus.inst_csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(all_out()), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_raddr", 64'(bus.csr_raddr), 64'h300);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    tick();

    // ecall with MIE=0, direct mtvec
    inst_wr(12'h305, 32'h8000_0100);
    exp_wr(12'h341, 32'h8000_0040);
    exp_wr(12'h342, 32'h0000_000b);
    exp_wr(12'h300, 32'h0000_1800);
    trap(1'b0, 32'h8000_0040, 32'h8000_0100);

    // mret back to mepc+4
    inst_wr(12'h341, 32'h8000_0044);
    bus.mret_req = 1'b1;
    exp_wr(12'h300, 32'h0000_1880);
    exp_rd(32'h8000_0044, 3);
    #1;
    chk("mret_busy", 64'(bus.busy), 64'd1);
    tick();
    bus.mret_req = 1'b0;
    tick();
    tick();
    chk("mret_redir_valid", 64'(bus.redirect_valid), 64'd1);
    tick();
    chk("mret_busy_drop", 64'(bus.busy), 64'd0);

    // irq beats simultaneous ecall, vectored mtvec
    inst_wr(12'h300, 32'h0000_0008);
    inst_wr(12'h305, 32'h8000_0101);
    exp_wr(12'h341, 32'h8000_0080);
    exp_wr(12'h342, 32'h8000_0007);
    exp_wr(12'h300, 32'h0000_1880);
    trap(1'b1, 32'h8000_0080, 32'h8000_011c);

    // CSR instruction write held across a trap sequence
    bus.ecall_req      = 1'b1;
    bus.ex_pc          = 32'h8000_0100;
    bus.inst_csr_wen   = 1'b1;
    bus.inst_csr_waddr = 12'h305;
    bus.inst_csr_wdata = 32'h0000_1234;
    exp_wr(12'h341, 32'h8000_0100);
    exp_wr(12'h342, 32'h0000_000b);
    exp_wr(12'h300, 32'h0000_1800);
    exp_wr(12'h305, 32'h0000_1234);
    exp_rd(32'h8000_0100, 5);
    #1;
    chk("blocked_ready", 64'(bus.inst_csr_ready), 64'd0);
    tick();
    bus.ecall_req = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      chk("blocked_ready", 64'(bus.inst_csr_ready), 64'd0);
      tick();
    end
    chk("released_ready", 64'(bus.inst_csr_ready), 64'd1);
    chk("released_wen", 64'(bus.csr_wen), 64'd1);
    tick();
    bus.inst_csr_wen = 1'b0;

    // reset during T_CAUSE aborts the sequence
    bus.ecall_req = 1'b1;
    bus.ex_pc     = 32'h8000_0200;
    exp_wr(12'h341, 32'h8000_0200);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd1);
    tick();
    bus.ecall_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'(all_out()), 64'd0);
    tick();
    tick();
    chk("abort_outputs_held", 64'(all_out()), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_idle_busy", 64'(bus.busy), 64'd0);
    tick();
    exp_wr(12'h341, 32'h8000_0300);
    exp_wr(12'h342, 32'h0000_000b);
    exp_wr(12'h300, 32'h0000_1800);
    trap(1'b0, 32'h8000_0300, 32'h0000_1234);

    // masked interrupt is ignored, instruction write proceeds
    bus.irq_pending = 1'b1;
    #1;
    chk("masked_busy", 64'(bus.busy), 64'd0);
    inst_wr(12'h305, 32'h8000_0100);
    chk("masked_busy_after", 64'(bus.busy), 64'd0);
    bus.irq_pending = 1'b0;

    repeat (8) tick();
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("redirects_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
